// File: rtl/io_sync_conditioner.sv
// Purpose : per-channel synchronizer -> consecutive-sample debouncer -> edge pulses.
// Latency : STAGES edges to sync_out, STAGES+DEBOUNCE_CYCLES edges to level/rise/fall.
// Backpressure: none; free-running, a sample is taken on every clk edge.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset, clears all state
//   async_in  [WIDTH] raw asynchronous inputs
//   sync_out  [WIDTH] last synchronizer stage
//   level     [WIDTH] debounced level
//   rise/fall [WIDTH] one-cycle pulses on accepted 0->1 / 1->0 level changes
module io_sync_conditioner #(
  parameter int WIDTH           = 1,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int              CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Plain shift chain: only stage 0 may go metastable, so nothing else
  // is allowed to tap or combine with the intermediate stages.
  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= async_in;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  logic [WIDTH-1:0] w_sync;
  assign w_sync   = r_sync[STAGES-1];
  assign sync_out = w_sync;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        // Pulses default low so they last exactly one cycle.
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (w_sync[g] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          // Mismatch has persisted DEBOUNCE_CYCLES edges: commit it.
          r_level <= w_sync[g];
          r_rise  <= w_sync[g];
          r_fall  <= ~w_sync[g];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign level[g] = r_level;
    assign rise[g]  = r_rise;
    assign fall[g]  = r_fall;
  end

endmodule
